// File: rtl/hc595_ctrl_if.sv
// hc595_ctrl_if: display-side bus between seg_static-style logic and the 74HC595 serialiser
//   en         : refresh enable                        (master -> slave)
//   sel[5:0]   : digit select, active high             (master -> slave)
//   seg[7:0]   : segment pattern, active low, [7] = DP (master -> slave)
//   frame_done : one-cycle pulse per completed frame   (slave -> master)
interface hc595_ctrl_if;
    logic       en;
    logic [5:0] sel;
    logic [7:0] seg;
    logic       frame_done;
    modport master (output en, sel, seg, input frame_done);
    modport slave  (input en, sel, seg, output frame_done);
endinterface

// File: rtl/hc595_ctrl.sv
// hc595_ctrl: serialises sel/seg snapshots into two daisy-chained 74HC595s in continuous refresh frames
//   sys_clk   : system clock, rising edge
//   sys_rst_n : synchronous active-low reset
//   bus       : slave side of hc595_ctrl_if (en, sel, seg in; frame_done out)
//   ds        : serial data to 595 SER
//   shcp      : 595 shift clock
//   stcp      : 595 storage (latch) clock
//   oe        : 595 output enable, active low; held off until the first frame is latched
module hc595_ctrl #(
    parameter int HALF_CYC = 2
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    hc595_ctrl_if.slave bus,
    output logic        ds,
    output logic        shcp,
    output logic        stcp,
    output logic        oe
);
    localparam logic [8:0] HC      = 9'(HALF_CYC);
    localparam logic [8:0] PH_LAST = 9'(2 * HALF_CYC - 1);
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, LATCH = 2'd2} state_t;
    state_t      state;
    logic [8:0]  ph;
    logic [3:0]  bit_cnt;
    logic [13:0] w;
    logic [13:0] snap;
    logic        ph_end;
    // sel is bit-reversed so that sel[0] lands nearest QA once all 14 bits are shifted
    assign snap   = {bus.sel[0], bus.sel[1], bus.sel[2], bus.sel[3], bus.sel[4], bus.sel[5], bus.seg};
    assign ph_end = ph == PH_LAST;
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state          <= IDLE;
            ph             <= '0;
            bit_cnt        <= '0;
            w              <= '0;
            ds             <= 1'b0;
            shcp           <= 1'b0;
            stcp           <= 1'b0;
            oe             <= 1'b1;
            bus.frame_done <= 1'b0;
        end else begin
            // outputs reflect the current (state, bit_cnt, ph), hence the one-cycle lag
            ds             <= state == SHIFT ? w[bit_cnt] : state == LATCH ? w[13] : 1'b0;
            shcp           <= state == SHIFT && ph >= HC;
            stcp           <= state == LATCH && ph < HC;
            bus.frame_done <= state == LATCH && ph_end;
            if (state == LATCH && ph_end)
                oe <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en) begin
                        w       <= snap;
                        ph      <= '0;
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    ph <= ph_end ? '0 : ph + 9'd1;
                    if (ph_end) begin
                        if (bit_cnt == 4'd13)
                            state <= LATCH;
                        else
                            bit_cnt <= bit_cnt + 4'd1;
                    end
                end
                LATCH: begin
                    ph <= ph_end ? '0 : ph + 9'd1;
                    if (ph_end) begin
                        bit_cnt <= '0;
                        state   <= bus.en ? SHIFT : IDLE;
                        if (bus.en)
                            w <= snap;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ph      <= '0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hc595_ctrl.sv
// tb_hc595_ctrl: scoreboard bench for hc595_ctrl at HALF_CYC=2 and HALF_CYC=1
module tb_hc595_ctrl;
    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic ds, shcp, stcp, oe, ds1, shcp1, stcp1, oe1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   exp_q[$];
    bit   exp1_q[$];
    int   fd_cyc[$];
    int   shcp_rises = 0;
    int   stcp_rises = 0;
    int   stcp_high = 0;
    int   last_stcp_shcp = 0;
    bit   overlap = 1'b0;
    logic oe_before_fd = 1'bx;
    logic prev_shcp = 1'b0;
    logic prev_stcp = 1'b0;
    logic prev_oe = 1'b1;

    hc595_ctrl_if bus ();
    hc595_ctrl_if bus1 ();

    hc595_ctrl #(.HALF_CYC(2)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus),
        .ds(ds), .shcp(shcp), .stcp(stcp), .oe(oe)
    );
    hc595_ctrl #(.HALF_CYC(1)) dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus1),
        .ds(ds1), .shcp(shcp1), .stcp(stcp1), .oe(oe1)
    );

    always #10 sys_clk = ~sys_clk;

    initial forever begin
        @(posedge sys_clk);
        cyc++;
    end

    // scoreboard side: every shcp rise of dut pops one expected ds bit
    initial begin : monitor
        bit e;
        forever begin
            @(negedge sys_clk);
            if (shcp === 1'b1 && prev_shcp !== 1'b1) begin
                shcp_rises++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL ds_extra: shift %0d ds=%b but no bit expected", shcp_rises, ds);
                end else begin
                    e = exp_q.pop_front();
                    if (ds !== e) begin
                        failures++;
                        $display("FAIL ds_bit: shift %0d ds=%b expected %b", shcp_rises, ds, e);
                    end
                end
            end
            if (stcp === 1'b1 && prev_stcp !== 1'b1) begin
                stcp_rises++;
                last_stcp_shcp = shcp_rises;
            end
            if (stcp === 1'b1) stcp_high++;
            if (shcp === 1'b1 && stcp === 1'b1) overlap = 1'b1;
            if (bus.frame_done === 1'b1) begin
                fd_cyc.push_back(cyc);
                oe_before_fd = prev_oe;
            end
            prev_shcp = shcp;
            prev_stcp = stcp;
            prev_oe = oe;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic push_frame(input logic [5:0] s, input logic [7:0] g, input bit which);
        for (int k = 0; k < 14; k++) begin
            if (which) exp1_q.push_back(k < 8 ? g[k] : s[13 - k]);
            else exp_q.push_back(k < 8 ? g[k] : s[13 - k]);
        end
    endtask

    task automatic wait_shifts(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget && shcp_rises < n; i++) begin
            @(negedge sys_clk);
            #1;
        end
        ok = shcp_rises >= n;
    endtask

    task automatic wait_fd(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget && fd_cyc.size() < n; i++) begin
            @(negedge sys_clk);
            #1;
        end
        ok = fd_cyc.size() >= n;
    endtask

    task automatic test_reset;
        sys_rst_n = 1'b0;
        bus.en = 1'b0; bus.sel = '0; bus.seg = '0;
        bus1.en = 1'b0; bus1.sel = '0; bus1.seg = '0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk); #1;
        checks++; if (ds !== 1'b0) begin failures++; $display("FAIL reset_ds: got %b want 0", ds); end
        checks++; if (shcp !== 1'b0) begin failures++; $display("FAIL reset_shcp: got %b want 0", shcp); end
        checks++; if (stcp !== 1'b0) begin failures++; $display("FAIL reset_stcp: got %b want 0", stcp); end
        checks++; if (oe !== 1'b1) begin failures++; $display("FAIL reset_oe: got %b want 1", oe); end
        checks++; if (bus.frame_done !== 1'b0) begin failures++; $display("FAIL reset_fd: got %b want 0", bus.frame_done); end
        checks++; if (oe1 !== 1'b1) begin failures++; $display("FAIL reset_oe1: got %b want 1", oe1); end
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        checks++; if (shcp !== 1'b0 || stcp !== 1'b0) begin failures++; $display("FAIL idle_no_en: shcp=%b stcp=%b want 0 0", shcp, stcp); end
    endtask

    task automatic test_continuous;
        int c0, sh0, st0, sth0, n0;
        bit ok;
        @(posedge sys_clk); #1;
        sh0 = shcp_rises; st0 = stcp_rises; sth0 = stcp_high; n0 = fd_cyc.size(); overlap = 1'b0;
        bus.sel = 6'b111111; bus.seg = 8'hC0;
        push_frame(6'b111111, 8'hC0, 1'b0);
        bus.en = 1'b1;
        c0 = cyc + 1;
        wait_shifts(sh0 + 5, 100, ok);
        checks++; if (!ok) begin failures++; $display("FAIL cont_bit5_timeout: shifts=%0d want %0d", shcp_rises - sh0, 5); end
        bus.seg = 8'hF9;
        push_frame(6'b111111, 8'hF9, 1'b0);
        push_frame(6'b111111, 8'hF9, 1'b0);
        wait_fd(n0 + 1, 200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL cont_fd1_timeout: frames=%0d want 1", fd_cyc.size() - n0); end
        checks++; if (fd_cyc[n0] != c0 + 60) begin failures++; $display("FAIL first_fd_time: cycle %0d want %0d", fd_cyc[n0], c0 + 60); end
        checks++; if (oe !== 1'b0 || oe_before_fd !== 1'b1) begin failures++; $display("FAIL oe_fall: oe=%b before=%b want 0 1", oe, oe_before_fd); end
        wait_fd(n0 + 2, 200, ok);
        bus.en = 1'b0;
        wait_fd(n0 + 3, 200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL cont_fd3_timeout: frames=%0d want 3", fd_cyc.size() - n0); end
        checks++; if (fd_cyc[n0 + 1] - fd_cyc[n0] != 60) begin failures++; $display("FAIL period_1_2: %0d want 60", fd_cyc[n0 + 1] - fd_cyc[n0]); end
        checks++; if (fd_cyc[n0 + 2] - fd_cyc[n0 + 1] != 60) begin failures++; $display("FAIL period_2_3: %0d want 60", fd_cyc[n0 + 2] - fd_cyc[n0 + 1]); end
        checks++; if (shcp_rises - sh0 != 42) begin failures++; $display("FAIL shcp_count: %0d want 42", shcp_rises - sh0); end
        checks++; if (stcp_rises - st0 != 3) begin failures++; $display("FAIL stcp_count: %0d want 3", stcp_rises - st0); end
        checks++; if (stcp_high - sth0 != 6) begin failures++; $display("FAIL stcp_width: %0d high cycles want 6", stcp_high - sth0); end
        checks++; if (overlap) begin failures++; $display("FAIL overlap: shcp and stcp high together, want never"); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL cont_leftover: %0d bits unshifted want 0", exp_q.size()); end
    endtask

    task automatic test_en_drop;
        int sh0, st0, n0;
        bit ok;
        repeat (5) @(negedge sys_clk);
        #1;
        checks++; if ({ds, shcp, stcp, oe} !== 4'b0000) begin failures++; $display("FAIL idle_after_cont: ds/shcp/stcp/oe=%b want 0000", {ds, shcp, stcp, oe}); end
        @(posedge sys_clk); #1;
        sh0 = shcp_rises; st0 = stcp_rises; n0 = fd_cyc.size();
        bus.sel = 6'b101010; bus.seg = 8'h92;
        push_frame(6'b101010, 8'h92, 1'b0);
        bus.en = 1'b1;
        wait_shifts(sh0 + 3, 100, ok);
        bus.en = 1'b0;
        wait_fd(n0 + 1, 200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL drop_fd_timeout: frames=%0d want 1", fd_cyc.size() - n0); end
        repeat (10) @(negedge sys_clk);
        #1;
        checks++; if (fd_cyc.size() != n0 + 1) begin failures++; $display("FAIL drop_frames: %0d want 1", fd_cyc.size() - n0); end
        checks++; if (shcp_rises - sh0 != 14) begin failures++; $display("FAIL drop_shifts: %0d want 14", shcp_rises - sh0); end
        checks++; if (stcp_rises - st0 != 1) begin failures++; $display("FAIL drop_latch: %0d want 1", stcp_rises - st0); end
        checks++; if ({ds, shcp, stcp, oe} !== 4'b0000) begin failures++; $display("FAIL drop_idle: ds/shcp/stcp/oe=%b want 0000", {ds, shcp, stcp, oe}); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL drop_leftover: %0d want 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid;
        int c0, sh0, sh1, st1, n1;
        bit ok;
        @(posedge sys_clk); #1;
        sh0 = shcp_rises;
        bus.sel = 6'b010101; bus.seg = 8'hA4;
        push_frame(6'b010101, 8'hA4, 1'b0);
        bus.en = 1'b1;
        wait_shifts(sh0 + 7, 100, ok);
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b0;
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        exp_q.delete();
        bus.sel = 6'b110011; bus.seg = 8'h5A;
        push_frame(6'b110011, 8'h5A, 1'b0);
        sh1 = shcp_rises; st1 = stcp_rises; n1 = fd_cyc.size();
        c0 = cyc + 1;
        @(negedge sys_clk); #1;
        checks++; if ({ds, shcp, stcp, oe, bus.frame_done} !== 5'b00010) begin failures++; $display("FAIL midreset_outs: ds/shcp/stcp/oe/fd=%b want 00010", {ds, shcp, stcp, oe, bus.frame_done}); end
        @(posedge sys_clk); #1;
        bus.en = 1'b0;
        wait_fd(n1 + 1, 200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL midreset_fd_timeout: frames=%0d want 1", fd_cyc.size() - n1); end
        checks++; if (fd_cyc[n1] != c0 + 60) begin failures++; $display("FAIL midreset_fd_time: cycle %0d want %0d", fd_cyc[n1], c0 + 60); end
        checks++; if (stcp_rises - st1 != 1 || last_stcp_shcp - sh1 != 14) begin failures++; $display("FAIL midreset_latch: stcp=%0d after %0d shifts want 1 after 14", stcp_rises - st1, last_stcp_shcp - sh1); end
        checks++; if (oe !== 1'b0 || oe_before_fd !== 1'b1) begin failures++; $display("FAIL midreset_oe: oe=%b before=%b want 0 1", oe, oe_before_fd); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL midreset_leftover: %0d want 0", exp_q.size()); end
    endtask

    task automatic test_half1;
        int c0, fdn, tog, fd0, fd1;
        logic p;
        bit e;
        @(posedge sys_clk); #1;
        push_frame(6'b111111, 8'hC0, 1'b1);
        push_frame(6'b111111, 8'hC0, 1'b1);
        bus1.sel = 6'b111111; bus1.seg = 8'hC0; bus1.en = 1'b1;
        c0 = cyc + 1;
        fdn = 0; tog = 0; fd0 = 0; fd1 = 0; p = 1'b0;
        for (int i = 0; i < 150 && fdn < 2; i++) begin
            @(negedge sys_clk); #1;
            if (shcp1 === 1'b1 && p !== 1'b1) begin
                checks++;
                if (exp1_q.size() == 0) begin
                    failures++;
                    $display("FAIL h1_ds_extra: ds=%b but no bit expected", ds1);
                end else begin
                    e = exp1_q.pop_front();
                    if (ds1 !== e) begin failures++; $display("FAIL h1_ds_bit: ds=%b expected %b", ds1, e); end
                end
            end
            if (fdn == 1 && shcp1 !== p) tog++;
            if (bus1.frame_done === 1'b1) begin
                if (fdn == 0) fd0 = cyc; else fd1 = cyc;
                fdn++;
                bus1.en = 1'b0;
            end
            p = shcp1;
        end
        checks++; if (fdn != 2) begin failures++; $display("FAIL h1_frames: %0d want 2", fdn); end
        checks++; if (fd0 != c0 + 30) begin failures++; $display("FAIL h1_first_fd: cycle %0d want %0d", fd0, c0 + 30); end
        checks++; if (fd1 - fd0 != 30) begin failures++; $display("FAIL h1_period: %0d want 30", fd1 - fd0); end
        checks++; if (tog != 28) begin failures++; $display("FAIL h1_toggles: %0d want 28", tog); end
        checks++; if (exp1_q.size() != 0) begin failures++; $display("FAIL h1_leftover: %0d want 0", exp1_q.size()); end
    endtask

    initial begin
        test_reset;
        test_continuous;
        test_en_drop;
        test_reset_mid;
        test_half1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
